// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU control encodings and FSM states for the ALU sequencer.
// Control constants are packed as {zx, nx, zy, ny, f, no}.
package alu_seq_pkg;

  localparam logic [3:0] OP_ZERO = 4'd0;
  localparam logic [3:0] OP_ONE  = 4'd1;
  localparam logic [3:0] OP_NEG1 = 4'd2;
  localparam logic [3:0] OP_X    = 4'd3;
  localparam logic [3:0] OP_Y    = 4'd4;
  localparam logic [3:0] OP_NOTX = 4'd5;
  localparam logic [3:0] OP_NEGX = 4'd6;
  localparam logic [3:0] OP_XINC = 4'd7;
  localparam logic [3:0] OP_XDEC = 4'd8;
  localparam logic [3:0] OP_ADD  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_RSUB = 4'd11;
  localparam logic [3:0] OP_AND  = 4'd12;
  localparam logic [3:0] OP_OR   = 4'd13;
  localparam logic [3:0] OP_ABSX = 4'd14;
  localparam logic [3:0] OP_MAX  = 4'd15;

  localparam logic [5:0] CTL_ZERO = 6'b101010;
  localparam logic [5:0] CTL_ONE  = 6'b111111;
  localparam logic [5:0] CTL_NEG1 = 6'b111010;
  localparam logic [5:0] CTL_X    = 6'b001100;
  localparam logic [5:0] CTL_Y    = 6'b110000;
  localparam logic [5:0] CTL_NOTX = 6'b001101;
  localparam logic [5:0] CTL_NEGX = 6'b001111;
  localparam logic [5:0] CTL_XINC = 6'b011111;
  localparam logic [5:0] CTL_XDEC = 6'b001110;
  localparam logic [5:0] CTL_ADD  = 6'b000010;
  localparam logic [5:0] CTL_SUB  = 6'b010011;
  localparam logic [5:0] CTL_RSUB = 6'b000111;
  localparam logic [5:0] CTL_AND  = 6'b000000;
  localparam logic [5:0] CTL_OR   = 6'b010101;
  localparam logic [5:0] CTL_OFF  = 6'b000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: selects ALU controls for the current pass
// and reports whether a second pass is required.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  input  logic       pass2,
  input  logic       sign,
  output logic [5:0] ctl,
  output logic       needs_pass2
);

  always_comb begin
    ctl         = CTL_OFF;
    needs_pass2 = 1'b0;
    if (!pass2) begin
      case (op)
        OP_ZERO: ctl = CTL_ZERO;
        OP_ONE:  ctl = CTL_ONE;
        OP_NEG1: ctl = CTL_NEG1;
        OP_X:    ctl = CTL_X;
        OP_Y:    ctl = CTL_Y;
        OP_NOTX: ctl = CTL_NOTX;
        OP_NEGX: ctl = CTL_NEGX;
        OP_XINC: ctl = CTL_XINC;
        OP_XDEC: ctl = CTL_XDEC;
        OP_ADD:  ctl = CTL_ADD;
        OP_SUB:  ctl = CTL_SUB;
        OP_RSUB: ctl = CTL_RSUB;
        OP_AND:  ctl = CTL_AND;
        OP_OR:   ctl = CTL_OR;
        OP_ABSX: begin
          ctl         = CTL_X;
          needs_pass2 = sign;
        end
        OP_MAX: begin
          ctl         = CTL_SUB;
          needs_pass2 = 1'b1;
        end
        default: ctl = CTL_OFF;
      endcase
    end else begin
      // Sign here is bit 15 of the pass-1 result held in the result register.
      case (op)
        OP_ABSX: ctl = CTL_NEGX;
        OP_MAX:  ctl = sign ? CTL_Y : CTL_X;
        default: ctl = CTL_OFF;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle sequencer driving an external 16-bit combinational ALU over
// valid/ready request and response channels.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             alu_en,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zr,
  output logic             rsp_ng
);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res;
  logic [5:0]       dec_ctl;
  logic [5:0]       ctl_out;
  logic             needs_pass2;
  logic             in_pass2;
  logic             sign;
  logic             accept;

  assign in_pass2 = (state == PASS2);
  // In PASS1 the sign comes straight from the ALU; in PASS2 from the stored pass-1 result.
  assign sign     = in_pass2 ? res[WIDTH-1] : alu_out[WIDTH-1];
  assign accept   = req_valid && req_ready;

  alu_seq_decode u_decode (
    .op          (op_q),
    .pass2       (in_pass2),
    .sign        (sign),
    .ctl         (dec_ctl),
    .needs_pass2 (needs_pass2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      res  <= '0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
      end
      if (state == PASS1 || state == PASS2) begin
        res <= alu_out;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_en    = 1'b0;
    ctl_out   = CTL_OFF;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = PASS1;
      end
      PASS1: begin
        alu_en    = 1'b1;
        ctl_out   = dec_ctl;
        state_nxt = needs_pass2 ? PASS2 : RESP;
      end
      PASS2: begin
        alu_en    = 1'b1;
        ctl_out   = dec_ctl;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctl_out;
  assign alu_x    = a_q;
  assign alu_y    = b_q;
  assign rsp_data = res;
  assign rsp_zr   = (res == '0);
  assign rsp_ng   = res[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural ALU attached to its control port.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        alu_en;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zr;
  logic        rsp_ng;

  typedef struct packed {
    logic [15:0] data;
    logic        zr;
    logic        ng;
    logic [3:0]  lat;
    logic [1:0]  passes;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_en    (alu_en),
    .alu_zx    (alu_zx),
    .alu_nx    (alu_nx),
    .alu_zy    (alu_zy),
    .alu_ny    (alu_ny),
    .alu_f     (alu_f),
    .alu_no    (alu_no),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zr    (rsp_zr),
    .rsp_ng    (rsp_ng)
  );

  // Stand-in for the external combinational ALU.
  always_comb begin
    logic [15:0] x1, y1, o;
    x1 = alu_zx ? 16'h0000 : alu_x;
    x1 = alu_nx ? ~x1 : x1;
    y1 = alu_zy ? 16'h0000 : alu_y;
    y1 = alu_ny ? ~y1 : y1;
    o  = alu_f ? (x1 + y1) : (x1 & y1);
    alu_out = alu_no ? ~o : o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t modelExpect(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [15:0] r;
    logic [15:0] diff;
    e.passes = 2'd1;
    diff = a - b;
    case (op)
      4'd0:  r = 16'h0000;
      4'd1:  r = 16'h0001;
      4'd2:  r = 16'hFFFF;
      4'd3:  r = a;
      4'd4:  r = b;
      4'd5:  r = ~a;
      4'd6:  r = 16'h0000 - a;
      4'd7:  r = a + 16'd1;
      4'd8:  r = a - 16'd1;
      4'd9:  r = a + b;
      4'd10: r = a - b;
      4'd11: r = b - a;
      4'd12: r = a & b;
      4'd13: r = a | b;
      4'd14: begin
        r = a[15] ? (16'h0000 - a) : a;
        e.passes = a[15] ? 2'd2 : 2'd1;
      end
      default: begin
        r = diff[15] ? b : a;
        e.passes = 2'd2;
      end
    endcase
    e.data = r;
    e.zr   = (r == 16'h0000);
    e.ng   = r[15];
    e.lat  = (e.passes == 2'd2) ? 4'd3 : 4'd2;
    return e;
  endfunction

  // Presents one request and returns at the accept edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int w;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    sb.push_back(modelExpect(op, a, b));
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("req_ready_wait", (w < 20), 1);
    @(posedge clk);
  endtask

  // Waits for the response, compares against the scoreboard, optionally stalls, then completes.
  task automatic collectResponse(input string tag, input int hold);
    exp_t        e;
    int          lat;
    int          en_cnt;
    logic [15:0] held;
    lat    = 0;
    en_cnt = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      lat++;
      if (!rsp_valid && alu_en) en_cnt++;
    end
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_latency"}, lat, 32'(e.lat));
    checkOutput({tag, "_alu_en_cycles"}, en_cnt, 32'(e.passes));
    checkOutput({tag, "_data"}, rsp_data, 32'(e.data));
    checkOutput({tag, "_zr"}, rsp_zr, 32'(e.zr));
    checkOutput({tag, "_ng"}, rsp_ng, 32'(e.ng));
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, rsp_valid, 1);
      checkOutput({tag, "_hold_data"}, rsp_data, 32'(held));
      checkOutput({tag, "_hold_req_ready"}, req_ready, 0);
      checkOutput({tag, "_hold_alu_en"}, alu_en, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_done_valid"}, rsp_valid, 0);
    checkOutput({tag, "_done_req_ready"}, req_ready, 1);
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_ADD;
    req_a     = 16'h1234;
    req_b     = 16'h4321;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_zr", rsp_zr, 1);
    checkOutput("rst_rsp_ng", rsp_ng, 0);
    checkOutput("rst_alu_en", alu_en, 0);
    checkOutput("rst_alu_x", alu_x, 0);
    checkOutput("rst_ctl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 0);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle", req_ready, 1);
    checkOutput("post_rst_no_rsp", rsp_valid, 0);

    // Abort an ADD while its response is pending.
    rsp_ready = 1'b0;
    applyStimulus(OP_ADD, 16'h0003, 16'h0004);
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      req_valid = 1'b0;
      w++;
    end
    checkOutput("abort_pre_valid", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_rsp_valid", rsp_valid, 0);
    checkOutput("abort_req_ready", req_ready, 1);
    checkOutput("abort_rsp_data", rsp_data, 0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);

    applyStimulus(OP_ADD, 16'h0003, 16'h0004);
    collectResponse("add", 0);
    applyStimulus(OP_SUB, 16'h0005, 16'h0005);
    collectResponse("sub_eq", 0);
    applyStimulus(OP_RSUB, 16'h0005, 16'h0007);
    collectResponse("rsub", 0);
    applyStimulus(OP_NOTX, 16'h00FF, 16'h0000);
    collectResponse("notx", 0);
    applyStimulus(OP_ABSX, 16'hFFFB, 16'h0000);
    collectResponse("absx_neg", 0);
    applyStimulus(OP_ABSX, 16'h0009, 16'h0000);
    collectResponse("absx_pos", 0);
    applyStimulus(OP_ABSX, 16'h8000, 16'h0000);
    collectResponse("absx_min", 0);
    applyStimulus(OP_MAX, 16'hFFFE, 16'h0003);
    collectResponse("max_y", 0);
    applyStimulus(OP_MAX, 16'h0010, 16'h000F);
    collectResponse("max_x", 0);

    rsp_ready = 1'b0;
    applyStimulus(OP_OR, 16'h00F0, 16'h0F00);
    collectResponse("or_bp", 5);

    for (int op = 0; op < 16; op++) begin
      applyStimulus(4'(op), 16'($urandom), 16'($urandom));
      collectResponse($sformatf("rand_op%0d", op), 0);
    end

    checkOutput("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
